rotate_sched: RTL and testbench
===============================

// Module: rotate_sched
// PURPOSE
//  Sequencing controller for an L-stage registered lane-rotate network built from mux_array stages.
//  Stage k rotates by 2**k lanes when its select is high: out[i] = in[(i+2**k)%N].
//  Accepts rotate requests over a valid/ready handshake and skews each select bit so it meets its data wave.
//  Emits out_valid when the rotated word leaves stage L-1.
//  Throttles intake with a credit counter sized to the downstream output buffer.
// PARAMETERS
//  N        8              lanes of 8 bits each; power of two, >=2
//  L        $clog2(N)      number of network stages (level 0..L-1)
//  CREDITS  4              downstream buffer slots; 1..15
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  req_valid    in   1   rotate request present; lane data is presented to stage 0 in the same cycle
//  req_ready    out  1   request accepted on a cycle with req_valid & req_ready
//  req_amt      in   L   rotation amount in lanes, 0..N-1
//  req_dir      in   1   0: out[i]=in[(i+amt)%N]; 1: out[i]=in[(i-amt)%N]
//  stage_sel    out  L   stage_sel[k] drives the s input of network stage k
//  out_valid    out  1   1-cycle pulse: stage L-1 output holds a rotated word
//  out_consume  in   1   downstream frees one buffer slot (pop)
//  credit_cnt   out  4   slots in use (in flight + buffered)
//  err_underflow out 1   sticky: out_consume seen while credit_cnt==0
// BEHAVIOUR
//  - Reset (reset==0) clears all state immediately:
//    - stage_sel=0, out_valid=0, credit_cnt=0, err_underflow=0, all skew/valid registers 0.
//    - req_ready is forced 0 while reset is low.
//  - Accept: acc = req_valid & req_ready.
//    - req_ready = (credit_cnt < CREDITS) & reset; derived from registered state only.
//    - No combinational path from req_valid or out_consume.
//  - Effective amount:
//    - eamt = req_dir ? (N - req_amt) mod N : req_amt, computed in L bits (wrap is natural).
//    - req_amt==0 with req_dir=1 gives eamt=0.
//  - Select skew, request accepted in cycle t:
//    - stage_sel[0] = acc ? eamt[0] : 0, combinational in cycle t.
//    - stage_sel[k] = eamt[k] registered k times (valid in cycle t+k); a bubble gives 0 (pass-through).
//  - Valid pipeline:
//    - Valid bit shifted L stages; out_valid high in cycle t+L.
//    - Total latency is L cycles, matching the L registered stages.
//  - Throughput: one request per cycle when credits allow. Back-to-back waves never share a stage select.
//  - credit_cnt:
//    - +1 on acc; -1 on out_consume (only when credit_cnt>0); acc and consume together leave it unchanged.
//    - Saturates at CREDITS by construction, because req_ready is 0 when full.
//  - Underflow: out_consume while credit_cnt==0 sets err_underflow and leaves credit_cnt at 0. Cleared only by reset.
//  - Reset mid-operation: in-flight waves are discarded and no out_valid is produced for them. Credits return to 0.
//  - req_amt and req_dir are sampled only on acc. Changes on cycles without acc have no effect.
// STRUCTURE
//  - Shared package rot_pkg:
//    - localparam function clog2 for L.
//    - DIR_FWD=1'b0, DIR_REV=1'b1.
//    - Credit counter width constant CW=4.
//  - Sub-module rotate_skew_pipe #(L): triangular delay line.
//    - Bit k delayed k cycles, plus an L-deep valid shift register.
//    - Registers reset to 0 asynchronously on reset low.
//  - Top level holds eamt arithmetic, credit counter, ready logic and the sticky error flag.
// TESTING (N=8, L=3, CREDITS=4)
//  - Release reset, req_valid=1, amt=3, dir=0, data lanes 0..7 = 0x00..0x07, accepted at t
//    -> stage_sel=001 @t, 010 @t+1 (no: amt=3 -> bits 1,1,0), i.e. sel[0]=1@t, sel[1]=1@t+1, sel[2]=0@t+2
//    -> out_valid @t+3, lanes = 03,04,05,06,07,00,01,02.
//  - amt=3, dir=1 -> eamt=5; sel[0]@t=1, sel[1]@t+1=0, sel[2]@t+2=1; out lane0=0x05.
//  - 4 back-to-back accepts, out_consume=0 -> credit_cnt=4 and req_ready=0 from cycle 4.
//    Then consume once -> ready=1 the next cycle.
//  - Accept plus out_consume in the same cycle with credit_cnt=2 -> credit_cnt stays 2.
//  - out_consume with credit_cnt=0 -> err_underflow=1 and stays 1; credit_cnt=0.
//  - Accept at t, reset low at t+1 -> no out_valid at t+3; after release, credit_cnt=0 and req_ready=1.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared constants and helpers for the lane-rotate sequencing controller.
package rot_pkg;

  typedef enum logic {
    DIR_FWD = 1'b0,
    DIR_REV = 1'b1
  } rot_dir_e;

  localparam int unsigned CW = 4;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    return res;
  endfunction

endpackage

// File: rtl/rotate_skew_pipe.sv
// Triangular select delay line: select bit k reaches its stage k cycles after accept,
// alongside an L-deep valid shift register.
module rotate_skew_pipe #(
  parameter int unsigned L = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_acc,
  input  logic [L-1:0] i_eamt,
  output logic [L-1:0] o_sel,
  output logic         o_valid
);

  logic [L-1:0] r_vld;

  // Stage 0 sees the wave in the accept cycle itself, so its select is not registered.
  assign o_sel[0] = i_acc & i_eamt[0];

  for (genvar k = 1; k < L; k++) begin : g_skew
    logic [k-1:0] r_dl;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_dl <= '0;
      end else begin
        r_dl[0] <= i_acc & i_eamt[k];
        for (int unsigned j = 1; j < k; j++) r_dl[j] <= r_dl[j-1];
      end
    end

    assign o_sel[k] = r_dl[k-1];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld[0] <= i_acc;
      for (int unsigned j = 1; j < L; j++) r_vld[j] <= r_vld[j-1];
    end
  end

  assign o_valid = r_vld[L-1];

endmodule

// File: rtl/rotate_sched.sv
// Sequencing controller for an L-stage registered lane-rotate network: handshake,
// effective-amount arithmetic, select skewing, credit throttling and underflow flag.
module rotate_sched
  import rot_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned L       = clog2(N),
  parameter int unsigned CREDITS = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [L-1:0]  req_amt,
  input  logic          req_dir,
  output logic [L-1:0]  stage_sel,
  output logic          out_valid,
  input  logic          out_consume,
  output logic [CW-1:0] credit_cnt,
  output logic          err_underflow
);

  logic [CW-1:0] r_credit;
  logic          r_err;
  logic          w_acc;
  logic [L-1:0]  w_eamt;
  rot_dir_e      w_dir;

  // Ready depends only on the credit register and reset, never on req_valid/out_consume.
  assign req_ready = reset & (r_credit < CW'(CREDITS));
  assign w_acc     = req_valid & req_ready;
  assign w_dir     = rot_dir_e'(req_dir);
  assign w_eamt    = (w_dir == DIR_REV) ? (L'(0) - req_amt) : req_amt;

  rotate_skew_pipe #(
    .L (L)
  ) u_skew (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_acc   (w_acc),
    .i_eamt  (w_eamt),
    .o_sel   (stage_sel),
    .o_valid (out_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_credit <= '0;
      r_err    <= 1'b0;
    end else begin
      if (out_consume && r_credit == '0) r_err <= 1'b1;
      if (w_acc && !out_consume) begin
        r_credit <= r_credit + CW'(1);
      end else if (!w_acc && out_consume && r_credit != '0) begin
        r_credit <= r_credit - CW'(1);
      end
    end
  end

  assign credit_cnt    = r_credit;
  assign err_underflow = r_err;

endmodule

// File: tb/tb_rotate_sched.sv
// Directed bench for rotate_sched with a behavioural 3-stage rotate network driven by stage_sel.
module tb_rotate_sched;

  localparam int unsigned N = 8;
  localparam int unsigned L = 3;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [L-1:0] req_amt;
  logic         req_dir;
  logic [L-1:0] stage_sel;
  logic         out_valid;
  logic         out_consume;
  logic [3:0]   credit_cnt;
  logic         err_underflow;

  logic [63:0]  data_in;
  logic [63:0]  r_d1, r_d2, r_d3;
  int           n_checks;
  int           n_errors;
  int           vcount;

  rotate_sched #(
    .N       (8),
    .CREDITS (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_amt       (req_amt),
    .req_dir       (req_dir),
    .stage_sel     (stage_sel),
    .out_valid     (out_valid),
    .out_consume   (out_consume),
    .credit_cnt    (credit_cnt),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane i occupies bits [8i+:8]; rotating by s lanes means out[i] = in[i+s].
  function automatic logic [63:0] rot(input logic [63:0] x, input int unsigned s);
    return (x >> (8 * s)) | (x << (64 - 8 * s));
  endfunction

  always @(posedge clk) begin
    r_d1 <= stage_sel[0] ? rot(data_in, 1) : data_in;
    r_d2 <= stage_sel[1] ? rot(r_d1, 2) : r_d1;
    r_d3 <= stage_sel[2] ? rot(r_d2, 4) : r_d2;
  end

  always @(negedge clk) if (out_valid) vcount++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nextc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  amt;
    logic        dir;
    logic [2:0]  esel;
    logic [63:0] eword;
  } vec_t;

  vec_t vt[6];

  initial begin
    n_checks = 0; n_errors = 0; vcount = 0;
    reset = 1'b0; req_valid = 1'b0; req_amt = '0; req_dir = 1'b0;
    out_consume = 1'b0; data_in = '0;

    vt[0] = '{3'd3, 1'b0, 3'b011, 64'h0201000706050403};
    vt[1] = '{3'd3, 1'b1, 3'b101, 64'h0403020100070605};
    vt[2] = '{3'd0, 1'b1, 3'b000, 64'h0706050403020100};
    vt[3] = '{3'd7, 1'b0, 3'b111, 64'h0605040302010007};
    vt[4] = '{3'd4, 1'b1, 3'b100, 64'h0302010007060504};
    vt[5] = '{3'd2, 1'b1, 3'b110, 64'h0504030201000706};

    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_sel", stage_sel, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_credit", credit_cnt, 0);
    chk("rst_err", err_underflow, 0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      nextc();
      req_valid = 1'b1; req_amt = vt[i].amt; req_dir = vt[i].dir;
      data_in = 64'h0706050403020100;
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), req_ready, 1);
      chk($sformatf("v%0d_sel0", i), stage_sel[0], vt[i].esel[0]);
      nextc();
      req_valid = 1'b0; req_amt = 3'd5; req_dir = ~req_dir; data_in = '0;
      @(negedge clk);
      chk($sformatf("v%0d_sel1", i), stage_sel[1], vt[i].esel[1]);
      chk($sformatf("v%0d_sel0_bubble", i), stage_sel[0], 0);
      nextc();
      @(negedge clk);
      chk($sformatf("v%0d_sel2", i), stage_sel[2], vt[i].esel[2]);
      chk($sformatf("v%0d_early_valid", i), out_valid, 0);
      nextc();
      @(negedge clk);
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_word", i), r_d3, vt[i].eword);
      chk($sformatf("v%0d_credit1", i), credit_cnt, 1);
      nextc();
      out_consume = 1'b1;
      nextc();
      out_consume = 1'b0;
      @(negedge clk);
      chk($sformatf("v%0d_credit0", i), credit_cnt, 0);
      chk($sformatf("v%0d_valid_pulse", i), out_valid, 0);
    end

    // Four back-to-back accepts fill the credits.
    for (int c = 0; c < 5; c++) begin
      nextc();
      req_valid = 1'b1; req_amt = 3'd1; req_dir = 1'b0;
      @(negedge clk);
      chk($sformatf("b2b_ready_c%0d", c), req_ready, (c < 4) ? 1 : 0);
      chk($sformatf("b2b_credit_c%0d", c), credit_cnt, (c < 4) ? c : 4);
    end
    nextc();
    req_valid = 1'b0; out_consume = 1'b1;
    nextc();
    out_consume = 1'b0;
    @(negedge clk);
    chk("pop_ready", req_ready, 1);
    chk("pop_credit", credit_cnt, 3);
    nextc();
    out_consume = 1'b1;
    nextc();
    @(negedge clk);
    chk("pre_both_credit", credit_cnt, 2);
    req_valid = 1'b1;
    nextc();
    req_valid = 1'b0; out_consume = 1'b0;
    @(negedge clk);
    chk("both_credit", credit_cnt, 2);
    nextc();
    out_consume = 1'b1;
    repeat (2) nextc();
    out_consume = 1'b0;
    @(negedge clk);
    chk("drain_credit", credit_cnt, 0);
    chk("drain_err", err_underflow, 0);

    // Underflow: pop with nothing held.
    nextc();
    out_consume = 1'b1;
    nextc();
    out_consume = 1'b0;
    @(negedge clk);
    chk("uf_err", err_underflow, 1);
    chk("uf_credit", credit_cnt, 0);
    repeat (3) nextc();
    @(negedge clk);
    chk("uf_sticky", err_underflow, 1);
    chk("uf_credit_hold", credit_cnt, 0);

    // Reset mid-flight discards the wave.
    vcount = 0;
    nextc();
    req_valid = 1'b1; req_amt = 3'd3; req_dir = 1'b0;
    nextc();
    req_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_credit", credit_cnt, 0);
    chk("mid_rst_sel", stage_sel, 0);
    chk("mid_rst_err", err_underflow, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    nextc();
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_credit", credit_cnt, 0);
    repeat (3) @(negedge clk);
    chk("post_rst_no_valid", vcount, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
